// File: rtl/bus_txn_ctrl.sv
// ---------------------------------------------------------------------------
// bus_txn_ctrl
//
// Control-side initiator for the shared 8-bit crypto interconnect bus.
// Accepts a transfer request from the sequencer, drives a one-byte header
// naming source and destination, releases the bus for a fixed handoff
// window, counts the payload bytes the source places on the bus, and closes
// the transaction with a one-cycle ack/done pulse.
//
// Optional feature macro: BUS_CTRL_TIMEOUT_EN
//   When defined, a DATA-state idle counter aborts a stalled transfer after
//   TIMEOUT_CYCLES consecutive cycles without bus_valid, sets the sticky
//   timeout_err flag and finishes with a normal ack/done pulse. When not
//   defined, DATA waits indefinitely and timeout_err is tied low.
//
// Parameters:
//   CTRL_ID         bus ID of this controller (header bits [1:0])
//   HANDOFF_CYCLES  idle cycles between header and first payload byte
//   TIMEOUT_CYCLES  idle-cycle limit in DATA (only with BUS_CTRL_TIMEOUT_EN)
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   req_valid    transfer request valid
//   req_ready    idle and able to accept a request
//   req_src      source module ID
//   req_dest     destination module ID
//   req_len      payload byte count (0 = header-only transfer)
//   ack          one-cycle end-of-transaction strobe to all bus interfaces
//   done         one-cycle completion pulse to the sequencer (same as ack)
//   timeout_err  sticky timeout flag, cleared on the next accepted request
//   byte_cnt     payload bytes observed in the current or last transaction
//   bus_data     shared bus data (tri-stated when not driven)
//   bus_valid    shared bus valid (tri-stated when not driven)
// ---------------------------------------------------------------------------
module bus_txn_ctrl #(
  parameter logic [1:0] CTRL_ID        = 2'b11,
  parameter int         HANDOFF_CYCLES = 3
`ifdef BUS_CTRL_TIMEOUT_EN
  ,
  parameter int         TIMEOUT_CYCLES = 255
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_src,
  input  logic [1:0] req_dest,
  input  logic [7:0] req_len,
  output logic       ack,
  output logic       done,
  output logic       timeout_err,
  output logic [7:0] byte_cnt,
  inout  wire  [7:0] bus_data,
  inout  wire        bus_valid
);

  localparam int HCW = (HANDOFF_CYCLES > 1) ? $clog2(HANDOFF_CYCLES) : 1;
  localparam logic [HCW-1:0] HC_LAST = HCW'(HANDOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    HANDOFF,
    DATA,
    ACK
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [HCW-1:0] handoff_cnt;
  logic [1:0]     src_q;
  logic [1:0]     dest_q;
  logic [7:0]     len_q;
  logic           accept;
  logic           byte_seen;
  logic           last_byte;
  logic           drive_hdr;
  logic [7:0]     header;

  assign accept    = (state == IDLE) && req_valid;
  // X or Z on the shared valid line never compares equal to 1, so it is
  // not counted as a byte.
  assign byte_seen = (bus_valid == 1'b1);
  assign last_byte = byte_seen && ((byte_cnt + 8'd1) == len_q);
  assign header    = {2'b00, dest_q, src_q, CTRL_ID};

  // Handshake and end-of-transaction strobes are pure state decodes; the
  // rst term keeps req_ready low for the whole time reset is held.
  assign req_ready = (state == IDLE) && !rst;
  assign ack       = (state == ACK);
  assign done      = (state == ACK);

  // The bus is driven only while the header is out. Gating with rst means
  // reset releases the bus in the same cycle, without waiting for a clock.
  assign drive_hdr = (state == HDR) && !rst;
  assign bus_data  = drive_hdr ? header : 8'bz;
  assign bus_valid = drive_hdr ? 1'b1 : 1'bz;

`ifdef BUS_CTRL_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] idle_cnt;
  logic       timeout_hit;
  logic       timeout_q;

  // The timeout fires on the cycle that would make TIMEOUT_CYCLES
  // consecutive cycles in DATA without a byte.
  assign timeout_hit = (state == DATA) && !byte_seen && (idle_cnt == TO_LAST);
  assign timeout_err = timeout_q;

  // Idle counter restarts on every counted byte and on leaving DATA, so it
  // only measures the current stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= 8'd0;
    end else if ((state != DATA) || byte_seen || timeout_hit) begin
      idle_cnt <= 8'd0;
    end else begin
      idle_cnt <= idle_cnt + 8'd1;
    end
  end

  // Sticky error: set by a timeout, cleared only by the next accepted
  // request so the sequencer can read it after done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else if (accept) begin
      timeout_q <= 1'b0;
    end else if (timeout_hit) begin
      timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic. Requests outside IDLE are simply ignored.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          state_nx = HDR;
        end
      end
      HDR: begin
        state_nx = HANDOFF;
      end
      HANDOFF: begin
        if (handoff_cnt == HC_LAST) begin
          state_nx = (len_q == 8'd0) ? ACK : DATA;
        end
      end
      DATA: begin
        if (last_byte) begin
          state_nx = ACK;
        end
`ifdef BUS_CTRL_TIMEOUT_EN
        else if (timeout_hit) begin
          state_nx = ACK;
        end
`endif
      end
      ACK: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Handoff counter walks 0..HANDOFF_CYCLES-1 while the bus is released
  // and sits at zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      handoff_cnt <= '0;
    end else if ((state == HANDOFF) && (handoff_cnt != HC_LAST)) begin
      handoff_cnt <= handoff_cnt + 1'b1;
    end else begin
      handoff_cnt <= '0;
    end
  end

  // Request fields are captured on the accepting edge so the header and
  // the length stay stable for the whole transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q  <= 2'b00;
      dest_q <= 2'b00;
      len_q  <= 8'd0;
    end else if (accept) begin
      src_q  <= req_src;
      dest_q <= req_dest;
      len_q  <= req_len;
    end
  end

  // Payload byte counter. Bytes count only in DATA, and the count never
  // passes len; valid seen in HANDOFF or ACK is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= 8'd0;
    end else if (accept) begin
      byte_cnt <= 8'd0;
    end else if ((state == DATA) && byte_seen && (byte_cnt != len_q)) begin
      byte_cnt <= byte_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_bus_txn_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bus_txn_ctrl
//
// Self-checking bench for bus_txn_ctrl. Each transaction is described by
// its request fields and a randomly gapped byte schedule; the expected
// header, handoff window, running count and ack cycle are derived from that
// schedule and compared cycle by cycle. Build with BUS_CTRL_TIMEOUT_EN to
// also exercise the timeout path (limit overridden to 8 cycles).
// ---------------------------------------------------------------------------
module tb_bus_txn_ctrl;

  localparam int HANDOFF      = 3;
  localparam int FIRST_DATA_K = 2 + HANDOFF;
`ifdef BUS_CTRL_TIMEOUT_EN
  localparam int TO_CYCLES    = 8;
`endif

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_src;
  logic [1:0] req_dest;
  logic [7:0] req_len;
  logic       ack;
  logic       done;
  logic       timeout_err;
  logic [7:0] byte_cnt;
  wire  [7:0] bus_data;
  wire        bus_valid;

  logic       tb_data_en;
  logic [7:0] tb_data;
  logic       tb_valid_en;
  logic       tb_valid;

  int vectors;
  int miscompares;

  assign bus_data  = tb_data_en  ? tb_data  : 8'bz;
  assign bus_valid = tb_valid_en ? tb_valid : 1'bz;

  bus_txn_ctrl #(
    .CTRL_ID        (2'b11),
    .HANDOFF_CYCLES (HANDOFF)
`ifdef BUS_CTRL_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (TO_CYCLES)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_src     (req_src),
    .req_dest    (req_dest),
    .req_len     (req_len),
    .ack         (ack),
    .done        (done),
    .timeout_err (timeout_err),
    .byte_cnt    (byte_cnt),
    .bus_data    (bus_data),
    .bus_valid   (bus_valid)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every vector and reports miscompares.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Confirms the controller is not driving: the bench drives all-zero
  // values and they must read back unchanged.
  task automatic checkReleased(input string tag);
    tb_data_en  = 1'b1;
    tb_data     = 8'h00;
    tb_valid_en = 1'b1;
    tb_valid    = 1'b0;
    #1;
    checkOutput({tag, "_data_z"},  bus_data,  8'h00);
    checkOutput({tag, "_valid_z"}, bus_valid, 1'b0);
    tb_data_en  = 1'b0;
    tb_valid_en = 1'b0;
  endtask

  task automatic releaseBus();
    tb_data_en  = 1'b0;
    tb_valid_en = 1'b0;
    tb_valid    = 1'b0;
  endtask

  // Presents a request in an idle cycle and returns just after the
  // accepting edge.
  task automatic presentRequest(input logic [1:0] src, input logic [1:0] dest,
                                input logic [7:0] len);
    @(posedge clk); #1;
    req_src   = src;
    req_dest  = dest;
    req_len   = len;
    req_valid = 1'b1;
    @(negedge clk);
    checkOutput("ready_before_req", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // One complete transaction. Cycle k counts from the accepting edge:
  // header in k=1, handoff k=2..4, payload from k=5, ack the cycle after
  // the len-th byte (k=5 when len is zero), idle again one cycle later.
  task automatic applyStimulus(input logic [1:0] src, input logic [1:0] dest,
                               input logic [7:0] len, input bit gapped,
                               input bit hold_req);
    bit         sched[$];
    int         ack_k;
    int         model_cnt;
    int         di;
    bit         spur;
    logic [7:0] hdr;

    hdr = {2'b00, dest, src, 2'b11};
    for (int b = 0; b < int'(len); b++) begin
      int gap;
      gap = gapped ? int'($urandom_range(0, 2)) : 0;
      repeat (gap) sched.push_back(1'b0);
      sched.push_back(1'b1);
    end
    ack_k     = FIRST_DATA_K + sched.size();
    model_cnt = 0;

    presentRequest(src, dest, len);
    req_valid = hold_req;

    for (int k = 1; k <= ack_k + 1; k++) begin
      spur = 1'b0;
      if (k >= ack_k) req_valid = 1'b0;
      if ((k >= 2) && (k < FIRST_DATA_K) && ($urandom_range(0, 1) == 1)) begin
        spur        = 1'b1;
        tb_valid_en = 1'b1;
        tb_valid    = 1'b1;
      end
      if ((k >= FIRST_DATA_K) && (k < ack_k)) begin
        di          = k - FIRST_DATA_K;
        tb_valid_en = 1'b1;
        tb_valid    = sched[di];
        tb_data_en  = 1'b1;
        tb_data     = 8'($urandom);
      end
      if (k == ack_k) begin
        tb_valid_en = 1'b1;
        tb_valid    = 1'b1;
      end

      @(negedge clk);
      if (k <= ack_k) checkOutput("ready_busy", req_ready, 1'b0);
      if (k == 1) begin
        checkOutput("hdr_data",  bus_data,    hdr);
        checkOutput("hdr_valid", bus_valid,   1'b1);
        checkOutput("hdr_cnt",   byte_cnt,    8'd0);
        checkOutput("hdr_err",   timeout_err, 1'b0);
        checkOutput("hdr_ack",   ack,         1'b0);
      end else if (k < FIRST_DATA_K) begin
        checkOutput("handoff_ack", ack, 1'b0);
        if (!spur) checkReleased("handoff");
      end else if (k < ack_k) begin
        checkOutput("data_cnt",  byte_cnt, 8'(model_cnt));
        checkOutput("data_ack",  ack,      1'b0);
        checkOutput("data_done", done,     1'b0);
        if (sched[di]) model_cnt++;
      end else if (k == ack_k) begin
        checkOutput("ack_pulse", ack,         1'b1);
        checkOutput("ack_done",  done,        1'b1);
        checkOutput("ack_cnt",   byte_cnt,    len);
        checkOutput("ack_err",   timeout_err, 1'b0);
      end else begin
        checkOutput("post_ack",   ack,      1'b0);
        checkOutput("post_done",  done,     1'b0);
        checkOutput("post_ready", req_ready, 1'b1);
        checkOutput("post_cnt",   byte_cnt, len);
      end
      @(posedge clk); #1;
      releaseBus();
    end
  endtask

`ifdef BUS_CTRL_TIMEOUT_EN
  // Stalled transfer: five bytes promised, two delivered. The controller
  // must give up roughly TO_CYCLES idle cycles after the last byte.
  task automatic runTimeout();
    bit seen;
    int ack_at;
    seen   = 1'b0;
    ack_at = 0;
    presentRequest(2'b00, 2'b01, 8'd5);
    for (int k = 1; (k <= 60) && !seen; k++) begin
      if ((k == FIRST_DATA_K) || (k == FIRST_DATA_K + 1)) begin
        tb_valid_en = 1'b1;
        tb_valid    = 1'b1;
      end
      @(negedge clk);
      if (ack) begin
        seen   = 1'b1;
        ack_at = k;
      end
      @(posedge clk); #1;
      releaseBus();
    end
    checkOutput("to_ack_seen", seen, 1'b1);
    checkOutput("to_window",
                ((ack_at - (FIRST_DATA_K + 1)) >= TO_CYCLES) &&
                ((ack_at - (FIRST_DATA_K + 1)) <= TO_CYCLES + 1), 1'b1);
    @(negedge clk);
    checkOutput("to_err_sticky", timeout_err, 1'b1);
    checkOutput("to_cnt",        byte_cnt,    8'd2);
  endtask
`endif

  // Reset in the middle of the handoff window: bus released at once, no
  // ack, count lost.
  task automatic runResetAbort();
    presentRequest(2'b10, 2'b01, 8'd3);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    checkReleased("rst_abort");
    checkOutput("rst_abort_ack",   ack,       1'b0);
    checkOutput("rst_abort_ready", req_ready, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("rst_hold_ack",  ack,      1'b0);
      checkOutput("rst_hold_done", done,     1'b0);
      checkOutput("rst_hold_cnt",  byte_cnt, 8'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_release_ready", req_ready, 1'b1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_src     = 2'b00;
    req_dest    = 2'b00;
    req_len     = 8'd0;
    releaseBus();
    tb_data     = 8'h00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkReleased("reset");
    checkOutput("reset_ack",   ack,         1'b0);
    checkOutput("reset_done",  done,        1'b0);
    checkOutput("reset_ready", req_ready,   1'b0);
    checkOutput("reset_cnt",   byte_cnt,    8'd0);
    checkOutput("reset_err",   timeout_err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_reset", req_ready, 1'b1);

    applyStimulus(2'b01, 2'b10, 8'd4, 1'b0, 1'b0);
    applyStimulus(2'($urandom), 2'($urandom), 8'd0, 1'b0, 1'b0);
    applyStimulus(2'b10, 2'b00, 8'd3, 1'b1, 1'b1);
    for (int t = 0; t < 8; t++) begin
      applyStimulus(2'($urandom), 2'($urandom), 8'($urandom_range(0, 12)),
                    1'($urandom), 1'($urandom));
    end

`ifdef BUS_CTRL_TIMEOUT_EN
    runTimeout();
    applyStimulus(2'b01, 2'b11, 8'd2, 1'b0, 1'b0);
`endif

    runResetAbort();
    applyStimulus(2'b11, 2'b01, 8'd5, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_txn_ctrl.md
# bus_txn_ctrl

Control-side initiator for the shared 8-bit crypto interconnect bus. It takes a transfer request from the top-level sequencer and drives the one-byte header that names the source and destination modules. It then releases the bus through a fixed 3-cycle handoff window, counts the payload bytes the source module places on the bus, and ends the transaction with a one-cycle `ack` pulse. It sits at bus ID 2'b11, alongside the per-module bus interfaces, and is the only block that opens and closes bus transactions.

## Interface
- `CTRL_ID`, 2'b11: bus ID of the controller, placed in header bits [1:0].
- `HANDOFF_CYCLES`, 3: idle cycles between the header and the first payload byte.
- `TIMEOUT_CYCLES`, 255: maximum consecutive cycles without `bus_valid` during DATA. Used only with `BUS_CTRL_TIMEOUT_EN`.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  transfer request valid.
- `req_ready`  out  1  controller is idle and accepts a request.
- `req_src`  in  2  ID of the source module.
- `req_dest`  in  2  ID of the destination module.
- `req_len`  in  8  payload byte count; 0 means a header-only transfer.
- `ack`  out  1  one-cycle end-of-transaction strobe, broadcast to all bus interfaces.
- `done`  out  1  one-cycle completion pulse to the sequencer, coincident with `ack`.
- `timeout_err`  out  1  sticky error flag, cleared on the next accepted request.
- `byte_cnt`  out  8  payload bytes observed in the current or last transaction.
- `bus_data`  inout  8  shared bus data, tri-stated when not driven.
- `bus_valid`  inout  1  shared bus valid, tri-stated when not driven.

## Operation
- Header byte layout: {2'b00, dest[1:0], src[1:0], CTRL_ID}.
- The header fields are latched from `req_src`/`req_dest` on the accepting edge.
- States:
  - IDLE → HDR when `req_valid && req_ready`. This edge latches `src`, `dest` and `len`, clears `byte_cnt`, and clears `timeout_err`.
  - HDR drives `bus_data` = header and `bus_valid` = 1 for exactly one cycle, then goes to HANDOFF.
  - HANDOFF holds the bus in Z for `HANDOFF_CYCLES` cycles. A handoff counter counts 0..HANDOFF_CYCLES-1. Exit goes to ACK if `len == 0`, otherwise to DATA.
  - DATA never drives the bus. Each cycle with `bus_valid === 1'b1` increments `byte_cnt`. When the increment makes `byte_cnt == len`, the next state is ACK. X or Z on `bus_valid` is not counted.
  - ACK asserts `ack` = 1 and `done` = 1 for one cycle, then returns to IDLE.
- `req_ready` = 1 only in IDLE and never while `rst` is asserted.
- `req_valid` in any other state is ignored; no request queueing.
- Tri-state drivers are purely combinational from state, so `rst` releases the bus immediately (asynchronously).
- `byte_cnt` saturates at `len`. Extra `bus_valid` cycles in the same cycle as the ACK transition are not counted.
- `bus_valid` seen during HANDOFF is ignored and not counted.

## Timing
- Reset values: state IDLE, `req_ready` = 0 during reset and 1 the first cycle after, `ack` 0, `done` 0, `timeout_err` 0, `byte_cnt` 0, `bus_data`/`bus_valid` Z.
- Accept edge T: header on the bus in cycle T+1; handoff covers T+2..T+4; first countable byte is in T+5.
- The transition out of DATA follows the edge that counts the last byte. With back-to-back bytes, `ack` falls at T+5+len, and `req_ready` returns at T+6+len.
- With `len == 0`, `ack` falls at T+5.
- Reset asserted mid-transaction aborts immediately: no `ack`, no `done`, and the count is lost.

## Configuration
- `BUS_CTRL_TIMEOUT_EN` defined:
  - A DATA-state idle counter resets on every counted byte and increments otherwise.
  - When it reaches `TIMEOUT_CYCLES`, `timeout_err` is set, the state goes to ACK, and `ack`/`done` pulse normally with the partial `byte_cnt`.
- Not defined: no idle counter. DATA waits indefinitely and `timeout_err` is tied to 0.

## Test plan
- Reset: hold `rst` for 3 cycles → bus Z, `ack` = 0, `req_ready` = 0. After release, `req_ready` = 1.
- Request src = 2'b01, dest = 2'b10, len = 4 → `bus_data` = 8'h27 with `bus_valid` = 1 for one cycle. Then 3 Z cycles. Bench drives 4 bytes back-to-back → `byte_cnt` = 4 and a single `ack`/`done` pulse one cycle after the 4th byte.
- len = 0 → header, 3 handoff cycles, then `ack` pulse 4 cycles after the header; `byte_cnt` = 0.
- len = 3 with gapped bytes (byte, 2 idle cycles, byte, 1 idle cycle, byte) → `ack` only after the 3rd byte. `bus_valid` pulsed during HANDOFF is not counted. `req_valid` held during DATA is not accepted.
- `BUS_CTRL_TIMEOUT_EN` with `TIMEOUT_CYCLES` = 8, len = 5, only 2 bytes sent → `timeout_err` = 1 and `ack` pulse with `byte_cnt` = 2. The next accepted request clears `timeout_err`.
- Assert `rst` during the HANDOFF cycle 2 → bus Z in the same cycle, no `ack`. After release, a new request completes normally.
